// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch front-end. Issues word fetches over a
//            req/gnt + in-order rvalid bus, buffers returned words together
//            with their PC in a prefetch FIFO and presents the FIFO head to
//            decode with valid/ready. Redirects flush the FIFO and mark every
//            still-pending response for discard.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: COTM32_IFU_MISALIGN_TRAP_EN
//   defined   : a redirect to a non word-aligned PC halts fetching and, once
//               all stale responses have drained, queues a single fault
//               marker entry {pc, 32'h0000_0013, fault=1}.
//   undefined : redirect PC bits [1:0] are forced to zero, o_fault is 0.
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   o_imem_req/o_imem_addr   fetch request and word address
//   i_imem_gnt               request accepted this cycle
//   i_imem_rvalid/_rdata     in-order read response
//   o_instr_valid/o_instr/o_instr_pc/o_fault   FIFO head toward decode
//   i_instr_ready            decode accepts head
//   i_redirect/_pc           flush and restart fetch at a new PC
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_fault,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam int          CW    = AW + 1;   // FIFO occupancy 0..FIFO_DEPTH
    // Outstanding requests can exceed FIFO_DEPTH right after a redirect
    // (discarded ones do not consume credit), so give the counters headroom.
    localparam int          IW    = AW + 2;
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_pc_mem  [FIFO_DEPTH];
    logic [31:0]   r_ins_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_inflight;
    logic [IW-1:0] r_discard;
    logic          r_active;     // first request only after reset release is synchronised

    logic [31:0]   w_redirect_pc;
    logic          w_halted;
    logic          w_trap_push;
    logic          w_grant;
    logic          w_rsp_live;
    logic          w_rsp_drop;
    logic          w_rsp_push;
    logic          w_push;
    logic          w_pop;
    logic [IW-1:0] w_credit;
    logic [31:0]   w_push_instr;

`ifdef COTM32_IFU_MISALIGN_TRAP_EN
    logic          r_halted;
    logic          r_trap_pend;
    logic          r_flt_mem [FIFO_DEPTH];

    assign w_redirect_pc = i_redirect_pc;
    assign w_halted      = r_halted;
    // The fault marker waits until every stale response has been dropped.
    assign w_trap_push   = r_trap_pend && (r_discard == '0) && !i_redirect;
    assign o_fault       = r_flt_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_halted    <= 1'b0;
            r_trap_pend <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_flt_mem[i] <= 1'b0;
            end
        end else begin
            if (i_redirect) begin
                r_halted    <= |i_redirect_pc[1:0];
                r_trap_pend <= |i_redirect_pc[1:0];
            end else if (w_trap_push) begin
                r_trap_pend <= 1'b0;
            end
            if (w_push) begin
                r_flt_mem[r_wr_ptr] <= !w_rsp_push;
            end
        end
    end
`else
    logic w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^i_redirect_pc[1:0];
    assign w_redirect_pc    = {i_redirect_pc[31:2], 2'b00};
    assign w_halted         = 1'b0;
    assign w_trap_push      = 1'b0;
    assign o_fault          = 1'b0;
`endif

    // Responses arriving with nothing outstanding (e.g. stale ones after a
    // reset) are ignored entirely.
    assign w_grant      = o_imem_req && i_imem_gnt;
    assign w_rsp_live   = i_imem_rvalid && (r_inflight != '0);
    assign w_rsp_drop   = w_rsp_live && (r_discard != '0);
    assign w_rsp_push   = w_rsp_live && (r_discard == '0) && !i_redirect;
    assign w_push       = w_rsp_push || w_trap_push;
    assign w_pop        = o_instr_valid && i_instr_ready && !i_redirect;
    assign w_push_instr = w_rsp_push ? i_imem_rdata : C_NOP;

    // Credit counts occupied slots plus every live (non-discarded) request,
    // so each response that will be pushed is guaranteed a FIFO slot.
    assign w_credit   = IW'(r_count) + r_inflight - r_discard;
    assign o_imem_req = r_active && !i_redirect && !w_halted &&
                        (w_credit < IW'(FIFO_DEPTH));

    assign o_imem_addr   = r_fetch_pc;
    assign o_instr_valid = (r_count != '0);
    assign o_instr       = r_ins_mem[r_rd_ptr];
    assign o_instr_pc    = r_pc_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pc_mem[i]  <= '0;
                r_ins_mem[i] <= '0;
            end
        end else begin
            r_active   <= 1'b1;
            r_inflight <= r_inflight + IW'(w_grant) - IW'(w_rsp_live);

            if (i_redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                // Everything still outstanding after this cycle is stale.
                r_discard  <= r_inflight - IW'(w_rsp_live);
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_drop) begin
                    r_discard <= r_discard - IW'(1);
                end
                if (w_push) begin
                    r_pc_mem[r_wr_ptr]  <= r_resp_pc;
                    r_ins_mem[r_wr_ptr] <= w_push_instr;
                    r_wr_ptr            <= r_wr_ptr + AW'(1);
                end
                if (w_rsp_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Scoreboard bench for instr_fetch_unit. Stimulus pushes the
//            expected decode-side entries; a monitor pops and compares on
//            every accepted output. A memory responder returns ~addr one
//            cycle after each grant, limited by a grant budget.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        i_clk         = 1'b0;
    logic        i_rst_n       = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt    = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata  = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_fault;
    logic        i_instr_ready = 1'b0;
    logic        i_redirect    = 1'b0;
    logic [31:0] i_redirect_pc = '0;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_fault       (o_fault),
        .i_instr_ready (i_instr_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    int   n_checks    = 0;
    int   n_fail      = 0;
    int   cyc         = 0;
    exp_t sb[$];
    exp_t e;
    int   first_pop   = -1;
    int   last_pop    = -1;

    logic [31:0] pend[$];
    int   budget       = 0;
    bit   rsp_en       = 1'b1;
    int   total_grants = 0;
    int   g0           = 0;

    always @(posedge i_clk) cyc++;

    // Memory model: response one cycle after grant, data = ~address.
    always @(negedge i_clk) begin
        #1;
        i_imem_gnt = (budget > 0);
        if (rsp_en && pend.size() > 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = ~pend.pop_front();
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = '0;
        end
        if (o_imem_req && i_imem_gnt) begin
            pend.push_back(o_imem_addr);
            budget--;
            total_grants++;
        end
    end

    // Monitor: every head accepted by decode is compared with the scoreboard.
    always @(negedge i_clk) begin
        #2;
        if (i_rst_n && o_instr_valid && i_instr_ready && !i_redirect) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_instr: got pc=%h instr=%h fault=%b, required no output",
                         o_instr_pc, o_instr, o_fault);
            end else begin
                e = sb.pop_front();
                if (o_instr_pc !== e.pc || o_instr !== e.instr || o_fault !== e.fault) begin
                    n_fail++;
                    $display("FAIL instr_out: got pc=%h instr=%h fault=%b, required pc=%h instr=%h fault=%b",
                             o_instr_pc, o_instr, o_fault, e.pc, e.instr, e.fault);
                end
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
    end

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        check32({nm, "_req"},   32'(o_imem_req),    32'h0);
        check32({nm, "_addr"},  o_imem_addr,        32'h0);
        check32({nm, "_valid"}, 32'(o_instr_valid), 32'h0);
        check32({nm, "_instr"}, o_instr,            32'h0);
        check32({nm, "_pc"},    o_instr_pc,         32'h0);
        check32({nm, "_fault"}, 32'(o_fault),       32'h0);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic flt);
        exp_t x;
        x.pc = pc; x.instr = instr; x.fault = flt;
        sb.push_back(x);
    endtask

    task automatic wait_drain(input string nm, input int lim);
        int k = 0;
        while (sb.size() != 0 && k < lim) begin
            @(negedge i_clk);
            k++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d entries outstanding, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_grants(input string nm, input int target, input int lim);
        int k = 0;
        while ((total_grants - g0) < target && k < lim) begin
            @(negedge i_clk);
            k++;
        end
        check32(nm, 32'(total_grants - g0), 32'(target));
    endtask

    task automatic wait_pend_empty(input string nm, input int lim);
        int k = 0;
        while (pend.size() != 0 && k < lim) begin
            @(negedge i_clk);
            k++;
        end
        check32(nm, 32'(pend.size()), 32'h0);
    endtask

    task automatic do_redirect(input logic [31:0] pc, input int new_budget);
        @(negedge i_clk);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        budget        = new_budget;
        g0            = total_grants;
        #3;
        check32("req_in_redirect", 32'(o_imem_req), 32'h0);
        @(negedge i_clk);
        i_redirect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge i_clk);
        check_zero_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Streaming: PCs 0,4,8,... one per cycle
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4), ~32'(i * 4), 1'b0);
        budget        = 8;
        i_instr_ready = 1'b1;
        first_pop     = -1;
        wait_drain("stream", 200);
        check32("stream_gapless", 32'(last_pop - first_pop), 32'd7);

        // Back-pressure: exactly FIFO_DEPTH grants, then drain in order
        @(negedge i_clk);
        i_instr_ready = 1'b0;
        do_redirect(32'h0000_0200, 100);
        repeat (20) @(negedge i_clk);
        check32("full_grants", 32'(total_grants - g0), 32'd4);
        check32("req_when_full", 32'(o_imem_req), 32'h0);
        budget = 0;
        for (int i = 0; i < 4; i++) push_exp(32'h200 + 32'(i * 4), ~(32'h200 + 32'(i * 4)), 1'b0);
        i_instr_ready = 1'b1;
        wait_drain("backpressure", 100);

        // Four in flight, redirect drops all of them
        @(negedge i_clk);
        i_instr_ready = 1'b0;
        rsp_en        = 1'b0;
        g0            = total_grants;
        budget        = 4;
        wait_grants("inflight_grants", 4, 50);
        do_redirect(32'h0000_0100, 0);
        rsp_en = 1'b1;
        wait_pend_empty("stale_drain", 50);
        repeat (3) @(negedge i_clk);
        check32("no_stale_push", 32'(o_instr_valid), 32'h0);
        push_exp(32'h100, ~32'h100, 1'b0);
        push_exp(32'h104, ~32'h104, 1'b0);
        budget        = 2;
        i_instr_ready = 1'b1;
        wait_drain("redirect", 100);

        // Address wrap
        push_exp(32'hFFFF_FFF8, ~32'hFFFF_FFF8, 1'b0);
        push_exp(32'hFFFF_FFFC, ~32'hFFFF_FFFC, 1'b0);
        push_exp(32'h0000_0000, ~32'h0000_0000, 1'b0);
        do_redirect(32'hFFFF_FFF8, 3);
        wait_drain("wrap", 100);

        // Async reset mid-burst with 3 in flight
        @(negedge i_clk);
        i_instr_ready = 1'b0;
        rsp_en        = 1'b0;
        g0            = total_grants;
        budget        = 3;
        wait_grants("pre_reset_grants", 3, 50);
        @(negedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(negedge i_clk);
        i_rst_n       = 1'b1;
        rsp_en        = 1'b1;
        i_instr_ready = 1'b1;
        wait_pend_empty("reset_stale_drain", 20);
        repeat (3) @(negedge i_clk);
        push_exp(32'h0, ~32'h0, 1'b0);
        push_exp(32'h4, ~32'h4, 1'b0);
        budget = 2;
        wait_drain("post_reset", 100);

        // Misaligned redirect
`ifdef COTM32_IFU_MISALIGN_TRAP_EN
        push_exp(32'h0000_0102, 32'h0000_0013, 1'b1);
        do_redirect(32'h0000_0102, 10);
        wait_drain("misalign_trap", 50);
        repeat (5) @(negedge i_clk);
        check32("misalign_no_req", 32'(total_grants - g0), 32'h0);
        budget = 0;
`else
        push_exp(32'h0000_0100, ~32'h0000_0100, 1'b0);
        do_redirect(32'h0000_0102, 1);
        wait_drain("misalign_forced", 50);
`endif
        repeat (5) @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
